// File: rtl/conv_window_scheduler.sv
// Convolution window sweep sequencer: walks output rows/columns and issues KER_SIZE column fetches per pixel.
// Optional stall performance counter enabled by defining SCHED_PERF_CNT_EN.
module conv_window_scheduler #(
  parameter int KER_SIZE    = 3,
  parameter int STRIDE      = 1,
  parameter int INPUT_X_DIM = 28,
  parameter int INPUT_Y_DIM = 28,
  parameter int PAD         = 1,
  parameter int AW          = 5
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          rows_ready,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [AW-1:0] col_addr,
  output logic          col_pad,
  output logic [3:0]    win_k,
  output logic          win_last,
  output logic [7:0]    out_x,
  output logic [7:0]    out_y,
  output logic          row_done,
  output logic          frame_done,
  output logic          busy,
  output logic [15:0]   stall_cycles
);

  localparam int OUT_X = (INPUT_X_DIM + 2*PAD - KER_SIZE)/STRIDE + 1;
  localparam int OUT_Y = (INPUT_Y_DIM + 2*PAD - KER_SIZE)/STRIDE + 1;

  localparam logic signed [AW+1:0] STRIDE_S   = (AW+2)'(STRIDE);
  localparam logic signed [AW+1:0] PAD_S      = (AW+2)'(PAD);
  localparam logic signed [AW+1:0] LAST_COL_S = (AW+2)'(INPUT_X_DIM-1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROWS,
    SWEEP,
    ROW_END,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [3:0] r_k;
  logic [7:0] r_ox;
  logic [7:0] r_oy;

  logic w_accept;
  logic w_lastK;
  logic w_lastX;
  logic w_lastY;
  logic signed [AW+1:0] w_x;
  logic w_outside;

  assign w_lastK  = (r_k  == 4'(KER_SIZE-1));
  assign w_lastX  = (r_ox == 8'(OUT_X-1));
  assign w_lastY  = (r_oy == 8'(OUT_Y-1));
  assign w_accept = (r_state == SWEEP) && win_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    win_valid   = 1'b0;
    row_done    = 1'b0;
    frame_done  = 1'b0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (start) w_nextState = WAIT_ROWS;
      end
      WAIT_ROWS: begin
        if (rows_ready) w_nextState = SWEEP;
      end
      SWEEP: begin
        win_valid = 1'b1;
        if (w_accept && w_lastK && w_lastX) w_nextState = ROW_END;
      end
      ROW_END: begin
        row_done    = 1'b1;
        w_nextState = w_lastY ? DONE : WAIT_ROWS;
      end
      DONE: begin
        frame_done  = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Sweep position: k runs fastest, then ox; oy advances once per finished row.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_k  <= '0;
      r_ox <= '0;
      r_oy <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_k  <= '0;
            r_ox <= '0;
            r_oy <= '0;
          end
        end
        SWEEP: begin
          if (w_accept) begin
            if (w_lastK) begin
              r_k  <= '0;
              r_ox <= w_lastX ? 8'd0 : r_ox + 8'd1;
            end else begin
              r_k <= r_k + 4'd1;
            end
          end
        end
        ROW_END: begin
          if (!w_lastY) r_oy <= r_oy + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Pad/address outputs are masked outside SWEEP so they read 0 at reset and between rows.
  assign w_x       = $signed((AW+2)'(r_ox)) * STRIDE_S + $signed((AW+2)'(r_k)) - PAD_S;
  assign w_outside = w_x[AW+1] || (w_x > LAST_COL_S);
  assign col_pad   = win_valid && w_outside;
  assign col_addr  = (win_valid && !w_outside) ? w_x[AW-1:0] : '0;
  assign win_k     = r_k;
  assign win_last  = w_lastK;
  assign out_x     = r_ox;
  assign out_y     = r_oy;

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall <= '0;
    end else if (r_state == IDLE && start) begin
      r_stall <= '0;
    end else if (((r_state == SWEEP && !win_ready) || r_state == WAIT_ROWS) &&
                 (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/conv_window_scheduler.md
Name: conv_window_scheduler

Overview:
Sequences the convolution window sweep over the line-buffer SRAM once the row controller reports that KER_SIZE rows are resident. For each output row it walks every output column and emits the KER_SIZE input-column fetches for each output pixel. Each fetch carries an SRAM column address and a left/right pad flag, and the fetches go to the MAC datapath over a valid/ready handshake. The block sits between the line-buffer row controller (rows_ready / row_done) and the MAC array input stage.

Parameters:
KER_SIZE 3 kernel width/height
STRIDE 1 horizontal and vertical stride (1..7)
INPUT_X_DIM 28 input columns
INPUT_Y_DIM 28 input rows
PAD 1 zero padding on each side (0..KER_SIZE-1)
AW 5 column address width
Derived: OUT_X = (INPUT_X_DIM + 2*PAD - KER_SIZE)/STRIDE + 1; OUT_Y likewise with INPUT_Y_DIM.

Ports:
clk input 1 clock
rstn input 1 reset, asynchronous, active-low
start input 1 frame start pulse; honoured only in IDLE
rows_ready input 1 line buffer holds the rows for the next output row
win_valid output 1 column fetch valid
win_ready input 1 MAC stage accepts fetch
col_addr output AW SRAM column address; 0 when col_pad=1
col_pad output 1 fetch column lies in left/right padding
win_k output 4 kernel column index 0..KER_SIZE-1
win_last output 1 win_k==KER_SIZE-1 (last fetch of pixel)
out_x output 8 current output column
out_y output 8 current output row
row_done output 1 one-cycle pulse: output row finished, line buffer may advance
frame_done output 1 one-cycle pulse: all OUT_Y rows finished
busy output 1 state != IDLE
stall_cycles output 16 performance counter (see Optional Feature)

Behaviour:
- Reset: state=IDLE. k, ox and oy are 0. win_valid, row_done, frame_done, busy, col_pad, col_addr and stall_cycles are all 0.
- FSM states: IDLE, WAIT_ROWS, SWEEP, ROW_END, DONE.
- IDLE: start=1 moves to WAIT_ROWS and clears k, ox and oy.
- WAIT_ROWS: rows_ready is sampled only in this state. rows_ready=1 moves to SWEEP on the next edge.
- SWEEP: win_valid=1 (decoded from registered state; no combinational path from win_ready). An accepted fetch is win_valid&&win_ready.
  - On accept with k<KER_SIZE-1: k++.
  - On accept with k==KER_SIZE-1: k=0 and ox++.
  - On accept with k==KER_SIZE-1 and ox==OUT_X-1: ox=0 and the FSM moves to ROW_END.
  - With no accept, all outputs hold stable.
- Column math: x = ox*STRIDE + k - PAD, computed signed in AW+2 bits.
  - col_pad = (x<0) || (x>INPUT_X_DIM-1).
  - col_addr = col_pad ? 0 : x[AW-1:0].
- ROW_END: row_done=1 for exactly one cycle.
  - If oy==OUT_Y-1, go to DONE.
  - Otherwise oy++ and go to WAIT_ROWS.
- DONE: frame_done=1 for exactly one cycle, then return to IDLE.
- Latency:
  - start to first win_valid is 2 cycles minimum, when rows_ready is already high.
  - Last accepted fetch to row_done is 1 cycle.
  - row_done to re-entry of SWEEP is 2 cycles minimum.
- Boundaries:
  - start outside IDLE is ignored.
  - rows_ready outside WAIT_ROWS is ignored.
  - rows_ready held high continuously is legal; the next row sweep starts at once.
  - win_ready held low stalls indefinitely with no state loss.
  - rstn asserted mid-frame aborts asynchronously to the reset values; a new start is required afterwards.
  - PAD=0 gives col_pad always 0.
  - OUT_X=1 gives exactly KER_SIZE fetches per row.

Optional Feature:
SCHED_PERF_CNT_EN.
- Defined: stall_cycles counts cycles with (state==SWEEP && !win_ready) or state==WAIT_ROWS. It saturates at 16'hFFFF, clears on reset and on an accepted start.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- K=3, PAD=1, STRIDE=1, X=Y=4, start with rows_ready=1 and win_ready=1. Required response:
  - ox=0 fetches col_pad=1,0,0 with col_addr 0,0,1.
  - ox=3 fetches col_addr 2,3 then col_pad=1.
  - 12 fetches per row, followed by a row_done pulse.
- Same configuration, full frame. Required response: 4 row_done pulses, then exactly one frame_done, then busy=0. Total fetches = 48.
- STRIDE=2, X=5, PAD=1 (OUT_X=3). Required response: fetch x sequence -1,0,1, 1,2,3, 3,4,5, with pads at -1 and 5.
- Hold win_ready=0 for 10 cycles mid-row. Required response: win_valid, col_addr and win_k are stable throughout. With SCHED_PERF_CNT_EN, stall_cycles increments by 10.
- Hold rows_ready=0 after a row_done. Required response: the FSM stays in WAIT_ROWS with win_valid=0. A start pulse in this state is ignored (ox, oy and k unchanged).
- Assert rstn low during SWEEP (ox=2). Required response: all outputs are immediately 0 and busy=0. After release, the FSM waits in IDLE until start.
